// File: rtl/johnson_ring_counter_nbit.sv
// WIDTH-bit Johnson / one-hot ring counter with a prescaled step enable,
// up/down direction, synchronous clear/load and registered complementary outputs.
module johnson_ring_counter_nbit #(
  parameter  int WIDTH = 4,
  parameter  int DIV   = 25_000_000,
  localparam int IW    = $clog2(2*WIDTH)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          en,
  input  logic          dir,
  input  logic          mode,
  input  logic          clear,
  input  logic          load,
  input  logic [IW-1:0] load_idx,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [IW-1:0] idx,
  output logic          tick,
  output logic          wrap,
  output logic          load_err
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [WIDTH-1:0] q_q, q_d, qbar_q;
  logic [IW-1:0]    idx_q, idx_d;
  logic [PW-1:0]    pre_q, pre_d, pre_inc;
  logic             mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic [IW:0]      n_states;
  logic [IW-1:0]    last_idx;
  logic             terminal;
  logic             load_ok;
  logic [WIDTH-1:0] up_v, dn_v;
  logic [IW-1:0]    up_idx, dn_idx;
  logic             up_wrap, dn_wrap;

  // Canonical bit pattern for state index k in the selected sequence.
  function automatic logic [WIDTH-1:0] decode(input logic [IW-1:0] k, input logic ring);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (ring)
        v[b] = (int'(k) == b);
      else if (int'(k) < WIDTH)
        v[b] = (b < int'(k));
      else
        v[b] = (b >= int'(k) - WIDTH);
    end
    return v;
  endfunction

  // Shift/rotate neighbours: the end bit is inverted for Johnson, passed through for ring.
  assign up_v[0]       = mode_q ? q_q[WIDTH-1] : ~q_q[WIDTH-1];
  assign dn_v[WIDTH-1] = mode_q ? q_q[0]       : ~q_q[0];

  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_shift
      assign up_v[gi]   = q_q[gi-1];
      assign dn_v[gi-1] = q_q[gi];
    end
  endgenerate

  assign n_states = mode_q ? (IW+1)'(WIDTH) : (IW+1)'(2*WIDTH);
  assign last_idx = IW'(n_states - 1'b1);
  assign load_ok  = ({1'b0, load_idx} < n_states);

  assign up_wrap  = (idx_q == last_idx);
  assign dn_wrap  = (idx_q == '0);
  assign up_idx   = up_wrap ? '0 : idx_q + 1'b1;
  assign dn_idx   = dn_wrap ? last_idx : idx_q - 1'b1;

  assign terminal = en && (pre_q == PW'(DIV - 1));
  assign pre_inc  = terminal ? '0 : pre_q + 1'b1;

  always_comb begin
    q_d    = q_q;
    idx_d  = idx_q;
    pre_d  = pre_q;
    mode_d = mode_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (clear || (mode != mode_q)) begin
      // Clear and mode realignment both restart the new sequence at index 0.
      mode_d = mode;
      q_d    = decode('0, mode);
      idx_d  = '0;
      pre_d  = '0;
    end else if (load) begin
      if (load_ok) begin
        q_d   = decode(load_idx, mode_q);
        idx_d = load_idx;
        pre_d = '0;
      end else begin
        err_d = 1'b1;
      end
    end else if (en) begin
      pre_d = pre_inc;
      if (terminal) begin
        tick_d = 1'b1;
        if (dir) begin
          q_d    = dn_v;
          idx_d  = dn_idx;
          wrap_d = dn_wrap;
        end else begin
          q_d    = up_v;
          idx_d  = up_idx;
          wrap_d = up_wrap;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q_q    <= '0;
      qbar_q <= '1;
      idx_q  <= '0;
      pre_q  <= '0;
      mode_q <= 1'b0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      qbar_q <= ~q_d;
      idx_q  <= idx_d;
      pre_q  <= pre_d;
      mode_q <= mode_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign q        = q_q;
  assign qbar     = qbar_q;
  assign idx      = idx_q;
  assign tick     = tick_q;
  assign wrap     = wrap_q;
  assign load_err = err_q;

endmodule
